// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor: one full-adder cell is reused for every bit
// position, LSB first, one bit per clock. Operands enter over a valid/ready
// handshake and the result, carry-out and signed overflow leave over another.
module serial_add_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_s;
    logic             fa_c;

    // The one shared adder cell; it sees the bit selected by the counter.
    Full_Adder2 u_fa (
        .A    (a_q[cnt]),
        .B    (b_q[cnt]),
        .CIN  (carry_q),
        .S    (fa_s),
        .CARRY(fa_c)
    );

    // Handshake flags come straight from the state register, so there is no
    // combinational path from IN_VALID or OUT_READY to either of them.
    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign SUM       = sum_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;

    // Sequencer: accept operands, walk the bits, hold the result until taken.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        // Subtraction is A + ~B + ~borrow_in, so invert B and CIN here.
                        a_q     <= A;
                        b_q     <= SUB ? ~B : B;
                        carry_q <= SUB ? ~CIN : CIN;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt] <= fa_s;
                    carry_q    <= fa_c;
                    if (cnt == LAST) begin
                        // carry_q still holds the carry into the MSB at this edge.
                        cout_q <= fa_c;
                        ovf_q  <= carry_q ^ fa_c;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// Single-bit full adder cell shared across all bit positions.
module Full_Adder2 (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic CARRY
);

    assign S     = A ^ B ^ CIN;
    assign CARRY = (A & B) | (CIN & (A ^ B));

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: an 8-bit and a 64-bit instance share the
// clock and reset; directed tables, multi-cycle corner cases and random
// operations checked against an arithmetic reference model.
module tb_serial_add_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, sub8, cin8, cout8, ovf8;
    logic [7:0] a8, b8, s8;

    logic        iv64, ir64, ov64, or64, sub64, cin64, cout64, ovf64;
    logic [63:0] a64, b64, s64;

    int vectors    = 0;
    int miscompares = 0;

    serial_add_sequencer #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8),
        .A(a8), .B(b8), .SUB(sub8), .CIN(cin8),
        .OUT_VALID(ov8), .OUT_READY(or8), .SUM(s8), .COUT(cout8), .OVF(ovf8)
    );

    serial_add_sequencer #(.WIDTH(64)) dut64 (
        .CLK(clk), .RST(rst), .IN_VALID(iv64), .IN_READY(ir64),
        .A(a64), .B(b64), .SUB(sub64), .CIN(cin64),
        .OUT_VALID(ov64), .OUT_READY(or64), .SUM(s64), .COUT(cout64), .OVF(ovf64)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Reference: true integer arithmetic on W-bit operands.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic cin,
                         output logic [63:0] s, output logic c, output logic o);
        logic [66:0]        ua, ub, ur, uc;
        logic signed [66:0] sa, sb, sc, tr, smax, smin;
        logic [63:0]        mask;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ua = {3'b0, a & mask};
        ub = {3'b0, b & mask};
        uc = {66'b0, cin};
        sa = ua;
        sb = ub;
        sc = uc;
        if (a[w-1]) sa = sa - (67'sd1 <<< w);
        if (b[w-1]) sb = sb - (67'sd1 <<< w);
        smax = (67'sd1 <<< (w - 1)) - 67'sd1;
        smin = -(67'sd1 <<< (w - 1));
        if (!sub) begin
            ur = ua + ub + uc;
            c  = ur[w];
            tr = sa + sb + sc;
        end else begin
            ur = ua - ub - uc;
            c  = (ua >= ub + uc);
            tr = sa - sb - sc;
        end
        s = ur[63:0] & mask;
        o = (tr > smax) || (tr < smin);
    endtask

    // Runs one operation on the selected instance; entered and left at a negedge.
    task automatic run_op(input bit w64, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic cin, input int stall,
                          output logic [63:0] sum, output logic cout, output logic ovf,
                          output int lat, output bit ok);
        int n;
        ok = 0; lat = 0; sum = '0; cout = 0; ovf = 0;
        n = 0;
        while (!(w64 ? ir64 : ir8) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            timeout("in_ready");
            return;
        end
        if (w64) begin
            a64 = a; b64 = b; sub64 = sub; cin64 = cin; iv64 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; cin8 = cin; iv8 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        iv64 = 1'b0;
        iv8  = 1'b0;
        check("in_ready_low_after_accept", {63'b0, (w64 ? ir64 : ir8)}, 64'd0);
        while (!(w64 ? ov64 : ov8) && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 300) begin
            timeout("out_valid");
            return;
        end
        repeat (stall) @(negedge clk);
        sum  = w64 ? s64 : {56'b0, s8};
        cout = w64 ? cout64 : cout8;
        ovf  = w64 ? ovf64 : ovf8;
        if (w64) or64 = 1'b1; else or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or64 = 1'b0;
        or8  = 1'b0;
        ok = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [63:0] sum, es;
        logic        cout, ovf, ec, eo, sub, cin;
        logic [63:0] a, b;
        int          lat;
        bit          ok;
        int          n;

        rst = 1'b1;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; sub8 = 0; cin8 = 0;
        iv64 = 0; or64 = 0; a64 = 0; b64 = 0; sub64 = 0; cin64 = 0;

        tbl.push_back('{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0});
        tbl.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        tbl.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0});
        tbl.push_back('{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1});

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready8", {63'b0, ir8}, 64'd1);
        check("rst_out_valid8", {63'b0, ov8}, 64'd0);
        check("rst_sum8", {56'b0, s8}, 64'd0);
        check("rst_cout8", {63'b0, cout8}, 64'd0);
        check("rst_ovf8", {63'b0, ovf8}, 64'd0);
        check("rst_in_ready64", {63'b0, ir64}, 64'd1);
        check("rst_out_valid64", {63'b0, ov64}, 64'd0);
        check("rst_sum64", s64, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed 8-bit table.
        for (int i = 0; i < tbl.size(); i++) begin
            run_op(1'b0, {56'b0, tbl[i].a}, {56'b0, tbl[i].b}, tbl[i].sub, tbl[i].cin, 0,
                   sum, cout, ovf, lat, ok);
            if (ok) begin
                check($sformatf("tbl%0d_sum", i), sum, {56'b0, tbl[i].sum});
                check($sformatf("tbl%0d_cout", i), {63'b0, cout}, {63'b0, tbl[i].cout});
                check($sformatf("tbl%0d_ovf", i), {63'b0, ovf}, {63'b0, tbl[i].ovf});
                check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd8);
                check($sformatf("tbl%0d_in_ready_after", i), {63'b0, ir8}, 64'd1);
                check($sformatf("tbl%0d_out_valid_after", i), {63'b0, ov8}, 64'd0);
            end
        end

        // Reset at bit 3 of an 8-bit operation (bit 3 is processed at accept edge + 4).
        a8 = 8'h5A; b8 = 8'h33; sub8 = 0; cin8 = 0; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_in_ready", {63'b0, ir8}, 64'd1);
        check("midrun_rst_out_valid", {63'b0, ov8}, 64'd0);
        check("midrun_rst_sum", {56'b0, s8}, 64'd0);
        check("midrun_rst_cout", {63'b0, cout8}, 64'd0);
        check("midrun_rst_ovf", {63'b0, ovf8}, 64'd0);
        run_op(1'b0, 64'h01, 64'h01, 1'b0, 1'b0, 0, sum, cout, ovf, lat, ok);
        if (ok) begin
            check("after_rst_sum", sum, 64'h02);
            check("after_rst_latency", 64'(lat), 64'd8);
        end

        // Backpressure in DONE with new operands being offered.
        a8 = 8'h12; b8 = 8'h34; sub8 = 0; cin8 = 0; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("bp_out_valid");
        iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; cin8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum", {56'b0, s8}, 64'h46);
            check("bp_cout", {63'b0, cout8}, 64'd0);
            check("bp_ovf", {63'b0, ovf8}, 64'd0);
            check("bp_in_ready", {63'b0, ir8}, 64'd0);
            check("bp_out_valid", {63'b0, ov8}, 64'd1);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
        check("bp_release_out_valid", {63'b0, ov8}, 64'd0);
        check("bp_release_in_ready", {63'b0, ir8}, 64'd1);
        @(negedge clk);
        check("bp_no_accept", {63'b0, ir8}, 64'd1);

        // 64-bit full carry ripple.
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, sum, cout, ovf, lat, ok);
        if (ok) begin
            check("w64_ripple_sum", sum, 64'd0);
            check("w64_ripple_cout", {63'b0, cout}, 64'd1);
            check("w64_ripple_ovf", {63'b0, ovf}, 64'd0);
            check("w64_ripple_latency", 64'(lat), 64'd64);
        end

        // Random operations with random result stalls on both widths.
        for (int i = 0; i < 1000; i++) begin
            bit w64;
            int w;
            w64 = (i < 400);
            w   = w64 ? 64 : 8;
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
            if ($urandom_range(0, 7) == 0) b = w64 ? 64'h8000_0000_0000_0000 : 64'h80;
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            if (!w64) begin
                a = a & 64'hFF;
                b = b & 64'hFF;
            end
            model(w, a, b, sub, cin, es, ec, eo);
            run_op(w64, a, b, sub, cin, int'($urandom_range(0, 3)), sum, cout, ovf, lat, ok);
            if (ok) begin
                check($sformatf("rand%0d_sum", i), sum, es);
                check($sformatf("rand%0d_cout", i), {63'b0, cout}, {63'b0, ec});
                check($sformatf("rand%0d_ovf", i), {63'b0, ovf}, {63'b0, eo});
                check($sformatf("rand%0d_latency", i), 64'(lat), 64'(w));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
